// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage RV32I pipeline.
// Selects the write value (ALU result, aligned/extended load data or PC+4)
// and drives one registered regfile write per retiring instruction. Holds
// the upstream pipeline while a load response is outstanding.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_cnt_o counter.
module wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            mem_valid_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [XLEN-1:0] mem_alu_i,
    input  logic [31:0]     mem_inst_i,
    input  logic            mem_wren_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [XLEN-1:0] ld_data_i,
    input  logic            ld_valid_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            retire_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt_o
`endif
);

    typedef enum logic {
        StIdle,
        StLoadWait
    } state_e;

    state_e          state_q;
    logic [4:0]      pend_rd_q;
    logic            pend_wren_q;
    logic [2:0]      pend_funct3_q;
    logic [1:0]      pend_off_q;

    logic [4:0]      inst_rd;
    logic [2:0]      inst_funct3;
    logic            accept;
    logic [XLEN-1:0] direct_val;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    // Opcode and the upper immediate/funct7 bits carry no information here.
    logic unused_inst;
    assign unused_inst = ^{mem_inst_i[31:15], mem_inst_i[6:0]};

    assign inst_rd     = mem_inst_i[11:7];
    assign inst_funct3 = mem_inst_i[14:12];

    // MEM is held for the whole time a load response is outstanding.
    assign stall_o = (state_q == StLoadWait);
    assign accept  = mem_valid_i & ~stall_o & ~flush_i;

    // Non-load write value: PC+4 for jumps, ALU result otherwise.
    always_comb begin
        direct_val = mem_alu_i;
        if (mem_wb_sel_i == 2'b10) begin
            direct_val = mem_pc_i + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    // Align and extend the returned word using the latched funct3/offset.
    always_comb begin
        ld_byte = ld_data_i[7:0];
        unique case (pend_off_q)
            2'd0: ld_byte = ld_data_i[7:0];
            2'd1: ld_byte = ld_data_i[15:8];
            2'd2: ld_byte = ld_data_i[23:16];
            2'd3: ld_byte = ld_data_i[31:24];
            default: ld_byte = ld_data_i[7:0];
        endcase
        // Halfword ignores off[0]: misaligned LH/LHU are not trapped here.
        ld_half = pend_off_q[1] ? ld_data_i[31:16] : ld_data_i[15:0];
        case (pend_funct3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = ld_data_i;
        endcase
    end

    // Writeback FSM with registered regfile port and retire pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            pend_rd_q     <= 5'd0;
            pend_wren_q   <= 1'b0;
            pend_funct3_q <= 3'd0;
            pend_off_q    <= 2'd0;
            rd_wren       <= 1'b0;
            rd_addr       <= 5'd0;
            rd_data       <= '0;
            retire_o      <= 1'b0;
        end else begin
            rd_wren  <= 1'b0;
            retire_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (mem_wb_sel_i == 2'b01) begin
                            pend_rd_q     <= inst_rd;
                            pend_wren_q   <= mem_wren_i;
                            pend_funct3_q <= inst_funct3;
                            pend_off_q    <= mem_alu_i[1:0];
                            state_q       <= StLoadWait;
                        end else begin
                            rd_wren  <= mem_wren_i & (inst_rd != 5'd0);
                            rd_addr  <= inst_rd;
                            rd_data  <= direct_val;
                            retire_o <= 1'b1;
                        end
                    end
                end
                StLoadWait: begin
                    // Flush wins over a same-cycle response; the data is dropped.
                    if (flush_i) begin
                        state_q <= StIdle;
                    end else if (ld_valid_i) begin
                        rd_wren  <= pend_wren_q & (pend_rd_q != 5'd0);
                        rd_addr  <= pend_rd_q;
                        rd_data  <= ld_ext;
                        retire_o <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count cycles with retire_o high; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retire_cnt_o <= '0;
        end else if (retire_o) begin
            retire_cnt_o <= retire_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed spec scenarios followed by
// random traffic compared against a transaction-level reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_alu;
    logic [31:0] mem_inst;
    logic        mem_wren;
    logic [1:0]  mem_wb_sel;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        flush;
    logic        stall;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        retire;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit          m_pend;
    logic [4:0]  m_prd;
    logic        m_pwren;
    logic [2:0]  m_pf3;
    logic [1:0]  m_poff;
    logic        m_wren;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_ret;
    logic [63:0] m_cnt;

    wb_stage dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .mem_valid_i  (mem_valid),
        .mem_pc_i     (mem_pc),
        .mem_alu_i    (mem_alu),
        .mem_inst_i   (mem_inst),
        .mem_wren_i   (mem_wren),
        .mem_wb_sel_i (mem_wb_sel),
        .ld_data_i    (ld_data),
        .ld_valid_i   (ld_valid),
        .flush_i      (flush),
        .stall_o      (stall),
        .rd_wren      (rd_wren),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .retire_o     (retire)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt_o (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
            end
            3'b001, 3'b101: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [2:0] f3);
        return {$urandom_range(0, 131071), f3, rd, 7'b0000011};
    endfunction

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input logic rst, input logic vld, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] inst, input logic wr,
                        input logic [1:0] sel, input logic [31:0] ld, input logic ldv,
                        input logic fl);
        logic [4:0] rd;
        @(negedge clk);
        rst_n = rst; mem_valid = vld; mem_pc = pc; mem_alu = alu; mem_inst = inst;
        mem_wren = wr; mem_wb_sel = sel; ld_data = ld; ld_valid = ldv; flush = fl;
        rd = inst[11:7];
        if (!rst) begin
            m_pend = 0; m_wren = 0; m_addr = 0; m_data = 0; m_ret = 0; m_cnt = 0;
        end else begin
            m_cnt = m_cnt + {63'd0, m_ret};
            m_wren = 0;
            m_ret = 0;
            if (m_pend) begin
                if (fl) m_pend = 0;
                else if (ldv) begin
                    m_wren = m_pwren && m_prd != 0;
                    m_addr = m_prd;
                    m_data = extract(m_pf3, m_poff, ld);
                    m_ret = 1;
                    m_pend = 0;
                end
            end else if (vld && !fl) begin
                if (sel == 2'b01) begin
                    m_pend = 1; m_prd = rd; m_pwren = wr; m_pf3 = inst[14:12]; m_poff = alu[1:0];
                end else begin
                    m_wren = wr && rd != 0;
                    m_addr = rd;
                    m_data = (sel == 2'b10) ? pc + 32'd4 : alu;
                    m_ret = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("stall", {63'd0, stall}, {63'd0, m_pend});
        chk("rd_wren", {63'd0, rd_wren}, {63'd0, m_wren});
        chk("retire", {63'd0, retire}, {63'd0, m_ret});
        chk("rd_addr", {59'd0, rd_addr}, {59'd0, m_addr});
        chk("rd_data", {32'd0, rd_data}, {32'd0, m_data});
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F80,
                                32'h80F17F80};

    initial begin
        rst_n = 0; mem_valid = 0; mem_pc = 0; mem_alu = 0; mem_inst = 0; mem_wren = 0;
        mem_wb_sel = 0; ld_data = 0; ld_valid = 0; flush = 0;
        m_pend = 0; m_prd = 0; m_pwren = 0; m_pf3 = 0; m_poff = 0;
        m_wren = 0; m_addr = 0; m_data = 0; m_ret = 0; m_cnt = 0;

        // Reset state
        step(0, 1, 32'h100, 32'hDEAD, mk_inst(5'd7, 3'b000), 1, 2'b00, 0, 0, 0);
        step(0, 1, 32'h100, 32'hDEAD, mk_inst(5'd7, 3'b000), 1, 2'b01, 0, 0, 0);
        chk("reset_data", {32'd0, rd_data}, 64'd0);

        // ALU op, then the pulse drops
        step(1, 1, 32'h40, 32'h1234, mk_inst(5'd5, 3'b000), 1, 2'b00, 0, 0, 0);
        chk("alu_data", {32'd0, rd_data}, 64'h1234);
        chk("alu_wren", {63'd0, rd_wren}, 64'd1);
        idle();
        chk("alu_wren_off", {63'd0, rd_wren}, 64'd0);

        // rd=x0 with PC+4 wrap
        step(1, 1, 32'hFFFFFFFC, 32'h55, mk_inst(5'd0, 3'b000), 1, 2'b10, 0, 0, 0);
        chk("x0_wren", {63'd0, rd_wren}, 64'd0);
        chk("x0_data", {32'd0, rd_data}, 64'd0);
        chk("x0_retire", {63'd0, retire}, 64'd1);

        // Load extraction table
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 32'h200, {30'h400, ld_off[i]}, mk_inst(5'd9, ld_f3[i]), 1, 2'b01,
                 32'h80F17F80, 1, 0);
            step(1, 1, 0, 0, 0, 0, 2'b00, 32'h80F17F80, 1, 0);
            chk("ld_extract", {32'd0, rd_data}, {32'd0, ld_exp[i]});
        end

        // Load wait: three stall cycles, then commit with stall low
        step(1, 1, 0, 32'h8, mk_inst(5'd3, 3'b010), 1, 2'b01, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h77, mk_inst(5'd4, 3'b000), 1, 2'b00, 32'h1, 0, 0);
            chk("wait_stall", {63'd0, stall}, 64'd1);
        end
        step(1, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 1, 0);
        chk("wait_commit", {32'd0, rd_data}, 64'hCAFEF00D);
        chk("wait_stall_drop", {63'd0, stall}, 64'd0);

        // Flush beats a simultaneous response
        step(1, 1, 0, 32'h0, mk_inst(5'd6, 3'b010), 1, 2'b01, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 2'b00, 32'h12345678, 1, 1);
        chk("flush_noret", {63'd0, retire}, 64'd0);
        chk("flush_stall", {63'd0, stall}, 64'd0);

        // Reset mid-load, later response must not commit
        step(1, 1, 0, 32'h0, mk_inst(5'd8, 3'b010), 1, 2'b01, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 2'b00, 32'hABCD, 1, 0);
        chk("rst_load_noret", {63'd0, retire}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h10, 32'h20 + i, mk_inst(5'd1, 3'b000), 1, 2'b00, 0, 0, 0);
        end
        idle();
`ifdef WB_RETIRE_CNT_EN
        chk("cnt_three", retire_cnt, 64'd3);
`endif

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom,
                 $urandom, $urandom, 1'($urandom), 2'($urandom), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
